// File: rtl/traffic_input_conditioner.sv
// Synchronises and debounces vehicle sensors and pedestrian buttons for the light FSM.
// Optional stuck-sensor detection is enabled by defining SENSOR_FAULT_EN.
module traffic_input_conditioner #(
    parameter int unsigned ON_CYC    = 5000,
    parameter int unsigned OFF_CYC   = 20000,
    parameter int unsigned BTN_CYC   = 200,
    parameter int unsigned STUCK_CYC = 6000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       SNN_RAW,
    input  logic       SNS_RAW,
    input  logic       STH_RAW,
    input  logic       PNN_RAW,
    input  logic       PNS_RAW,
    input  logic       PTH_RAW,
    input  logic       CLR_PNN,
    input  logic       CLR_PNS,
    input  logic       CLR_PTH,
    output logic       SNN,
    output logic       SNS,
    output logic       STH,
    output logic       PNN,
    output logic       PNS,
    output logic       PTH,
    output logic [2:0] FAULT
);

    localparam logic [15:0] ON_THR  = 16'(ON_CYC);
    localparam logic [15:0] OFF_THR = 16'(OFF_CYC);
    localparam logic [15:0] BTN_THR = 16'(BTN_CYC);

    // Bits [2:0] are the sensors {STH, SNS, SNN}, bits [5:3] the buttons {PTH, PNS, PNN}.
    logic [5:0] raw;
    logic [5:0] meta_q;
    logic [5:0] sync_q;
    logic [2:0] clr;

    assign raw = {PTH_RAW, PNS_RAW, PNN_RAW, STH_RAW, SNS_RAW, SNN_RAW};
    assign clr = {CLR_PTH, CLR_PNS, CLR_PNN};

    logic [2:0]  sen_lvl_q, sen_lvl_d;
    logic [15:0] sen_cnt_q [3];
    logic [15:0] sen_cnt_d [3];

    logic [2:0]  btn_lvl_q, btn_lvl_d;
    logic [2:0]  btn_prev_q;
    logic [15:0] btn_cnt_q [3];
    logic [15:0] btn_cnt_d [3];

    logic [2:0]  req_q, req_d;
    logic [2:0]  fault_q;

    always_comb begin
        sen_lvl_d = sen_lvl_q;
        btn_lvl_d = btn_lvl_q;
        req_d     = req_q;
        for (int i = 0; i < 3; i++) begin
            sen_cnt_d[i] = 16'd0;
            btn_cnt_d[i] = 16'd0;

            // Level flips one edge after the counter has reached its threshold.
            if (sync_q[i] != sen_lvl_q[i]) begin
                if (sen_cnt_q[i] == (sen_lvl_q[i] ? OFF_THR : ON_THR)) begin
                    sen_lvl_d[i] = sync_q[i];
                end else begin
                    sen_cnt_d[i] = sen_cnt_q[i] + 16'd1;
                end
            end

            if (sync_q[i+3] != btn_lvl_q[i]) begin
                if (btn_cnt_q[i] == BTN_THR) begin
                    btn_lvl_d[i] = sync_q[i+3];
                end else begin
                    btn_cnt_d[i] = btn_cnt_q[i] + 16'd1;
                end
            end

            // A fresh press edge outranks a simultaneous served strobe.
            req_d[i] = (btn_lvl_q[i] & ~btn_prev_q[i]) | (req_q[i] & ~clr[i]);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            meta_q     <= '0;
            sync_q     <= '0;
            sen_lvl_q  <= '0;
            btn_lvl_q  <= '0;
            btn_prev_q <= '0;
            req_q      <= '0;
            for (int i = 0; i < 3; i++) begin
                sen_cnt_q[i] <= '0;
                btn_cnt_q[i] <= '0;
            end
        end else begin
            meta_q     <= raw;
            sync_q     <= meta_q;
            sen_lvl_q  <= sen_lvl_d;
            btn_lvl_q  <= btn_lvl_d;
            btn_prev_q <= btn_lvl_q;
            req_q      <= req_d;
            for (int i = 0; i < 3; i++) begin
                sen_cnt_q[i] <= sen_cnt_d[i];
                btn_cnt_q[i] <= btn_cnt_d[i];
            end
        end
    end

`ifdef SENSOR_FAULT_EN
    logic [31:0] stuck_cnt_q [3];
    logic [31:0] stuck_cnt_d [3];

    // Counts cycles of high debounced level; clears on the edge the level drops.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            if (!sen_lvl_d[i]) begin
                stuck_cnt_d[i] = 32'd0;
            end else if (sen_lvl_q[i] && (stuck_cnt_q[i] != STUCK_CYC)) begin
                stuck_cnt_d[i] = stuck_cnt_q[i] + 32'd1;
            end else begin
                stuck_cnt_d[i] = stuck_cnt_q[i];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            fault_q <= '0;
            for (int i = 0; i < 3; i++) begin
                stuck_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                stuck_cnt_q[i] <= stuck_cnt_d[i];
                fault_q[i]     <= (stuck_cnt_d[i] == STUCK_CYC);
            end
        end
    end
`else
    assign fault_q = 3'b000;
`endif

    assign SNN   = sen_lvl_q[0] & ~fault_q[0];
    assign SNS   = sen_lvl_q[1] & ~fault_q[1];
    assign STH   = sen_lvl_q[2] & ~fault_q[2];
    assign PNN   = req_q[0];
    assign PNS   = req_q[1];
    assign PTH   = req_q[2];
    assign FAULT = fault_q;

endmodule

// File: tb/tb_traffic_input_conditioner.sv
// Directed bench for traffic_input_conditioner with ON=4, OFF=8, BTN=3, STUCK=50.
module tb_traffic_input_conditioner;

    logic       CLK;
    logic       RST_N;
    logic       SNN_RAW, SNS_RAW, STH_RAW;
    logic       PNN_RAW, PNS_RAW, PTH_RAW;
    logic       CLR_PNN, CLR_PNS, CLR_PTH;
    logic       SNN, SNS, STH;
    logic       PNN, PNS, PTH;
    logic [2:0] FAULT;

    int checks;
    int failures;

    traffic_input_conditioner #(
        .ON_CYC   (4),
        .OFF_CYC  (8),
        .BTN_CYC  (3),
        .STUCK_CYC(50)
    ) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .SNN_RAW(SNN_RAW),
        .SNS_RAW(SNS_RAW),
        .STH_RAW(STH_RAW),
        .PNN_RAW(PNN_RAW),
        .PNS_RAW(PNS_RAW),
        .PTH_RAW(PTH_RAW),
        .CLR_PNN(CLR_PNN),
        .CLR_PNS(CLR_PNS),
        .CLR_PTH(CLR_PTH),
        .SNN    (SNN),
        .SNS    (SNS),
        .STH    (STH),
        .PNN    (PNN),
        .PNS    (PNS),
        .PTH    (PTH),
        .FAULT  (FAULT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        RST_N    = 1'b0;
        SNN_RAW  = 1'b0;
        SNS_RAW  = 1'b0;
        STH_RAW  = 1'b0;
        PNN_RAW  = 1'b0;
        PNS_RAW  = 1'b0;
        PTH_RAW  = 1'b0;
        CLR_PNN  = 1'b0;
        CLR_PNS  = 1'b0;
        CLR_PTH  = 1'b0;
        step(3);
        RST_N = 1'b1;
        chk("rst_snn", {31'd0, SNN}, 32'd0);
        chk("rst_sns", {31'd0, SNS}, 32'd0);
        chk("rst_sth", {31'd0, STH}, 32'd0);
        chk("rst_pnn", {31'd0, PNN}, 32'd0);
        chk("rst_pns", {31'd0, PNS}, 32'd0);
        chk("rst_pth", {31'd0, PTH}, 32'd0);
        chk("rst_fault", {29'd0, FAULT}, 32'd0);

        // Sensor assert at 2+4 edges after first high sample, release at 2+8.
        SNN_RAW = 1'b1;
        step(6);
        chk("snn_early", {31'd0, SNN}, 32'd0);
        step(1);
        chk("snn_assert", {31'd0, SNN}, 32'd1);
        step(20);
        chk("snn_hold", {31'd0, SNN}, 32'd1);
        chk("sns_idle", {31'd0, SNS}, 32'd0);
        chk("sth_idle", {31'd0, STH}, 32'd0);
        SNN_RAW = 1'b0;
        step(10);
        chk("snn_rel_early", {31'd0, SNN}, 32'd1);
        step(1);
        chk("snn_release", {31'd0, SNN}, 32'd0);

        // Glitch: 3 high, 1 low, then high; rise 6 edges after the final rising sample.
        STH_RAW = 1'b1;
        step(3);
        STH_RAW = 1'b0;
        step(1);
        STH_RAW = 1'b1;
        step(3);
        chk("sth_glitch_a", {31'd0, STH}, 32'd0);
        step(3);
        chk("sth_glitch_b", {31'd0, STH}, 32'd0);
        step(1);
        chk("sth_glitch_rise", {31'd0, STH}, 32'd1);
        STH_RAW = 1'b0;
        step(12);
        chk("sth_release", {31'd0, STH}, 32'd0);

        // Button request rises 6 edges after press, latches, clears on strobe.
        PNS_RAW = 1'b1;
        step(6);
        chk("pns_early", {31'd0, PNS}, 32'd0);
        step(1);
        chk("pns_set", {31'd0, PNS}, 32'd1);
        step(3);
        PNS_RAW = 1'b0;
        step(10);
        chk("pns_latched", {31'd0, PNS}, 32'd1);
        CLR_PNS = 1'b1;
        step(1);
        CLR_PNS = 1'b0;
        chk("pns_clear", {31'd0, PNS}, 32'd0);
        step(2);
        chk("pns_stay_clear", {31'd0, PNS}, 32'd0);
        chk("pnn_idle", {31'd0, PNN}, 32'd0);

        // Second press edge coincides with the served strobe; the set must win.
        PTH_RAW = 1'b1;
        step(7);
        chk("pth_first", {31'd0, PTH}, 32'd1);
        PTH_RAW = 1'b0;
        step(8);
        PTH_RAW = 1'b1;
        step(6);
        CLR_PTH = 1'b1;
        step(1);
        CLR_PTH = 1'b0;
        chk("pth_set_wins", {31'd0, PTH}, 32'd1);
        step(3);
        CLR_PTH = 1'b1;
        step(1);
        CLR_PTH = 1'b0;
        chk("pth_cleared", {31'd0, PTH}, 32'd0);
        step(95);
        chk("pth_hold_single", {31'd0, PTH}, 32'd0);
        PTH_RAW = 1'b0;
        step(10);
        chk("pth_after_rel", {31'd0, PTH}, 32'd0);

        // Latch a PNN request so reset has something to clear.
        PNN_RAW = 1'b1;
        step(7);
        chk("pnn_set", {31'd0, PNN}, 32'd1);
        PNN_RAW = 1'b0;
        step(8);

        // Reset with the SNN counter at 3; full 2+4 needed afterwards.
        SNN_RAW = 1'b1;
        step(5);
        RST_N = 1'b0;
        step(1);
        RST_N = 1'b1;
        chk("mid_rst_snn", {31'd0, SNN}, 32'd0);
        chk("mid_rst_pnn", {31'd0, PNN}, 32'd0);
        chk("mid_rst_fault", {29'd0, FAULT}, 32'd0);
        step(6);
        chk("post_rst_early", {31'd0, SNN}, 32'd0);
        step(1);
        chk("post_rst_assert", {31'd0, SNN}, 32'd1);

`ifdef SENSOR_FAULT_EN
        step(49);
        chk("stuck_pre_snn", {31'd0, SNN}, 32'd1);
        chk("stuck_pre_fault", {29'd0, FAULT}, 32'd0);
        step(1);
        chk("stuck_fault", {29'd0, FAULT}, 32'd1);
        chk("stuck_snn_forced", {31'd0, SNN}, 32'd0);
        SNN_RAW = 1'b0;
        step(10);
        chk("stuck_fault_held", {29'd0, FAULT}, 32'd1);
        step(1);
        chk("stuck_fault_clr", {29'd0, FAULT}, 32'd0);
        chk("stuck_snn_low", {31'd0, SNN}, 32'd0);
`else
        step(50);
        chk("nofault_snn", {31'd0, SNN}, 32'd1);
        chk("nofault_fault", {29'd0, FAULT}, 32'd0);
        SNN_RAW = 1'b0;
        step(11);
        chk("nofault_release", {31'd0, SNN}, 32'd0);
        chk("nofault_fault_end", {29'd0, FAULT}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
